fetch2decode_queue: RTL and testbench

FETCH2DECODE_QUEUE -- requirements
Module: fetch2decode_queue

---
 rtl/fetch2decode_queue_pkg.sv | 34 +++
 rtl/fetch2decode_queue_pipe_delay.sv | 29 ++
 rtl/fetch2decode_queue.sv | 113 +++++++++++
 tb/tb_fetch2decode_queue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch2decode_queue_pkg.sv
// Shared core types for the fetch-to-decode boundary: decode packets and
// branch-predictor update packets.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 4
`endif

package fetch2decode_queue_pkg;

  localparam int unsigned FetchWidth = `FETCH_WIDTH;

  typedef enum logic [1:0] {
    CtrlNone,
    CtrlBranch,
    CtrlJump,
    CtrlRet
  } ctrl_type_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } decPkt;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    ctrl_type_e  ctrlType;
    logic        dir;
    logic [1:0]  counter;
    logic [7:0]  index;
    logic        en;
  } predUpdPkt;

endpackage

// File: rtl/fetch2decode_queue_pipe_delay.sv
// Fixed-latency delay line: q_o is d_i delayed by exactly STAGES clocks.
module pipe_delay #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/fetch2decode_queue.sv
// Bundle queue between fetch and decode, plus a fixed-latency predictor
// update path that runs independently of the queue.
module fetch2decode_queue
  import fetch2decode_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = `FETCH_WIDTH,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned AFULL_THRESH = DEPTH - 1,
  parameter int unsigned UPD_STAGES   = 1,
  localparam int unsigned CntW        = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [FETCH_WIDTH-1:0]    laneActive_i,
  input  logic                      push_i,
  input  decPkt [FETCH_WIDTH-1:0]   decPacket_i,
  output logic                      push_ready_o,
  input  logic                      pop_i,
  output decPkt [FETCH_WIDTH-1:0]   decPacket_o,
  output logic                      bundle_valid_o,
  output logic [CntW-1:0]           count_o,
  output logic                      afull_o,
  input  predUpdPkt                 upd_i,
  output predUpdPkt                 upd_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            afull_q, afull_d;

  decPkt [FETCH_WIDTH-1:0] mem_q [DEPTH];
  decPkt [FETCH_WIDTH-1:0] push_bundle;

  logic full, empty, do_push, do_pop;

  // Ready depends only on registered occupancy, so there is no pop_i -> ready path.
  assign full           = (count_q == CntW'(DEPTH));
  assign empty          = (count_q == '0);
  assign push_ready_o   = ~full;
  assign bundle_valid_o = ~empty;
  assign count_o        = count_q;
  assign afull_o        = afull_q;

  assign do_push = push_i & ~full & ~flush_i;
  assign do_pop  = pop_i & ~empty & ~flush_i;

  always_comb begin
    push_bundle = decPacket_i;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      push_bundle[i].valid = decPacket_i[i].valid & laneActive_i[i];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) count_d = count_q + CntW'(1);
      if (do_pop && !do_push) count_d = count_q - CntW'(1);
    end
    afull_d = (count_d >= CntW'(AFULL_THRESH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      afull_q  <= afull_d;
    end
  end

  // Storage is not reset; stale contents are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_bundle;
    end
  end

  always_comb begin
    decPacket_o = mem_q[rd_ptr_q];
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      decPacket_o[i].valid = mem_q[rd_ptr_q][i].valid & ~empty;
    end
  end

  pipe_delay #(
    .WIDTH  ($bits(predUpdPkt)),
    .STAGES (UPD_STAGES)
  ) u_upd_delay (
    .clk   (clk),
    .reset (reset),
    .d_i   (upd_i),
    .q_o   (upd_o)
  );

endmodule

// File: tb/tb_fetch2decode_queue.sv
// Directed plus randomized bench for fetch2decode_queue against a queue-based
// behavioural model of occupancy, ordering, lane masking and update latency.
module tb_fetch2decode_queue;
  import fetch2decode_queue_pkg::*;

  localparam int unsigned FW         = `FETCH_WIDTH;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned UPD_STAGES = 2;
  localparam int unsigned CntW       = $clog2(DEPTH) + 1;

  typedef decPkt [FW-1:0] bundle_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush_i;
  logic [FW-1:0]   laneActive_i;
  logic            push_i;
  bundle_t         decPacket_i;
  logic            push_ready_o;
  logic            pop_i;
  bundle_t         decPacket_o;
  logic            bundle_valid_o;
  logic [CntW-1:0] count_o;
  logic            afull_o;
  predUpdPkt       upd_i;
  predUpdPkt       upd_o;

  fetch2decode_queue #(
    .DEPTH      (DEPTH),
    .UPD_STAGES (UPD_STAGES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .flush_i        (flush_i),
    .laneActive_i   (laneActive_i),
    .push_i         (push_i),
    .decPacket_i    (decPacket_i),
    .push_ready_o   (push_ready_o),
    .pop_i          (pop_i),
    .decPacket_o    (decPacket_o),
    .bundle_valid_o (bundle_valid_o),
    .count_o        (count_o),
    .afull_o        (afull_o),
    .upd_i          (upd_i),
    .upd_o          (upd_o)
  );

  always #5 clk = ~clk;

  bundle_t     model_q[$];
  predUpdPkt   upd_hist[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] valids(input bundle_t b);
    logic [FW-1:0] v;
    for (int i = 0; i < FW; i++) v[i] = b[i].valid;
    return v;
  endfunction

  function automatic bundle_t make_bundle(input logic [31:0] pc, input logic [FW-1:0] v);
    bundle_t b;
    for (int i = 0; i < FW; i++) begin
      b[i].valid = v[i];
      b[i].pc    = pc + 32'(4 * i);
      b[i].instr = $urandom;
    end
    return b;
  endfunction

  function automatic predUpdPkt rand_upd(input logic en);
    predUpdPkt u;
    u.pc       = $urandom;
    u.npc      = $urandom;
    u.ctrlType = ctrl_type_e'($urandom_range(0, 3));
    u.dir      = 1'($urandom);
    u.counter  = 2'($urandom);
    u.index    = 8'($urandom);
    u.en       = en;
    return u;
  endfunction

  function automatic predUpdPkt exp_upd();
    if (upd_hist.size() >= UPD_STAGES) return upd_hist[upd_hist.size() - UPD_STAGES];
    return '0;
  endfunction

  // Model: a queue of bundles; flush empties it, pop takes the front, push appends if room.
  task automatic model_step();
    bundle_t b;
    bit      acc;
    if (!reset) begin
      model_q.delete();
      upd_hist.delete();
    end else begin
      upd_hist.push_back(upd_i);
      if (flush_i) begin
        model_q.delete();
      end else begin
        acc = push_i && (model_q.size() < DEPTH);
        if (pop_i && model_q.size() > 0) void'(model_q.pop_front());
        if (acc) begin
          b = decPacket_i;
          for (int i = 0; i < FW; i++) b[i].valid = decPacket_i[i].valid & laneActive_i[i];
          model_q.push_back(b);
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":count"}, count_o, model_q.size());
    chk({tag, ":valid"}, bundle_valid_o, model_q.size() != 0);
    chk({tag, ":ready"}, push_ready_o, model_q.size() < DEPTH);
    chk({tag, ":afull"}, afull_o, model_q.size() >= DEPTH - 1);
    if (model_q.size() != 0) chk({tag, ":head"}, decPacket_o, model_q[0]);
    else chk({tag, ":headv"}, valids(decPacket_o), '0);
    chk({tag, ":upd"}, upd_o, exp_upd());
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] pcs [3];
    pcs[0] = 32'h100; pcs[1] = 32'h110; pcs[2] = 32'h120;
    flush_i = 0; push_i = 0; pop_i = 0; laneActive_i = '1;
    decPacket_i = '0; upd_i = '0;

    #12;
    check_all("reset");
    reset = 1'b1;

    // Fill to DEPTH, then one dropped push.
    push_i = 1;
    for (int i = 0; i < 4; i++) begin
      decPacket_i = make_bundle(32'(i * 16), '1);
      tick("fill");
      chk("fill_count", count_o, i + 1);
      chk("fill_afull", afull_o, (i + 1) >= 3);
    end
    chk("fill_ready", push_ready_o, 1'b0);
    decPacket_i = make_bundle(32'h999, '1);
    tick("fill5");
    chk("drop_count", count_o, 4);

    push_i = 0; pop_i = 1;
    repeat (5) tick("drain");
    chk("pop_empty", count_o, 0);

    // Ordering.
    pop_i = 0; push_i = 1;
    for (int k = 0; k < 3; k++) begin
      decPacket_i = make_bundle(pcs[k], '1);
      tick("order_push");
    end
    push_i = 0; pop_i = 1;
    for (int k = 0; k < 3; k++) begin
      chk("order_pc", decPacket_o[0].pc, pcs[k]);
      tick("order_pop");
    end
    chk("order_empty", bundle_valid_o, 1'b0);

    // Simultaneous push/pop at count 2 across pointer wrap.
    pop_i = 0; push_i = 1;
    for (int k = 0; k < 2; k++) begin
      decPacket_i = make_bundle(32'(32'h200 + k * 16), '1);
      tick("sim_pre");
    end
    pop_i = 1;
    for (int k = 0; k < 10; k++) begin
      decPacket_i = make_bundle(32'(32'h300 + k * 16), 4'($urandom));
      tick("sim");
      chk("sim_count", count_o, 2);
    end

    // Flush beats a concurrent push.
    pop_i = 0;
    decPacket_i = make_bundle(32'h400, '1);
    tick("flush_pre");
    flush_i = 1;
    decPacket_i = make_bundle(32'h500, '1);
    tick("flush");
    chk("flush_count", count_o, 0);
    chk("flush_valid", bundle_valid_o, 1'b0);
    flush_i = 0; push_i = 0;
    tick("flush_post");

    // Lane mask.
    laneActive_i = 4'b0101; push_i = 1;
    decPacket_i = make_bundle(32'h600, '1);
    tick("mask_push");
    laneActive_i = '1; push_i = 0;
    chk("mask_valids", valids(decPacket_o), 4'b0101);
    pop_i = 1;
    tick("mask_pop");
    pop_i = 0;

    // Update pulse with flush held high.
    flush_i = 1;
    upd_i = rand_upd(1'b1);
    tick("upd_t0");
    upd_i = rand_upd(1'b0);
    tick("upd_t1");
    chk("upd_en", upd_o.en, 1'b1);
    flush_i = 0;

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      push_i       = 1'($urandom);
      pop_i        = 1'($urandom);
      flush_i      = ($urandom_range(0, 19) == 0);
      laneActive_i = 4'($urandom);
      decPacket_i  = make_bundle($urandom, 4'($urandom));
      upd_i        = rand_upd(1'($urandom));
      tick("rand");
    end

    // Reset mid-fill takes effect without a clock edge.
    flush_i = 1; push_i = 0; pop_i = 0;
    tick("pre_rst_flush");
    flush_i = 0; push_i = 1;
    tick("pre_rst_fill");
    tick("pre_rst_fill");
    push_i = 0;
    #2;
    reset = 1'b0;
    model_q.delete();
    upd_hist.delete();
    #1;
    check_all("midreset");
    #10;
    reset = 1'b1;
    push_i = 1;
    decPacket_i = make_bundle(32'h700, '1);
    tick("post_rst");
    chk("post_rst_count", count_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
